// File: rtl/rst_seq_ctrl.sv
// Reset release sequencer: holds all stage resets for a minimum window after
// reset/abort, then releases them one at a time in bit order and flags done.
module rst_seq_ctrl #(
  parameter int NUM_STAGES  = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 8,
  parameter int CNT_W       = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clk_stable,
  input  logic                  i_sw_rst_req,
  output logic [NUM_STAGES-1:0] o_rstn_stage,
  output logic                  o_rst_done,
  output logic                  o_busy
);

  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [CNT_W-1:0]      HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]      GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_STAGES - 1);
  localparam logic [NUM_STAGES-1:0] FIRST_REL = NUM_STAGES'(1);

  typedef enum logic [1:0] {S_HOLD, S_REL, S_DONE} state_e;

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [IDX_W-1:0]      idx_q;
  logic [NUM_STAGES-1:0] rstn_q;
  logic                  done_q;
  logic                  busy_q;
  logic                  abort;

  // Loss of clock-good or a SW request behaves exactly like i_rst in every
  // state: in S_HOLD it restarts the window, elsewhere it drops all stages.
  assign abort = !i_clk_stable || i_sw_rst_req;

  always_ff @(posedge i_clk) begin
    if (i_rst || abort) begin
      state_q <= S_HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      rstn_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        S_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_q <= S_REL;
            cnt_q   <= '0;
            idx_q   <= '0;
            rstn_q  <= FIRST_REL;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_REL: begin
          if (cnt_q == GAP_LAST) begin
            cnt_q <= '0;
            if (idx_q == IDX_LAST) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              idx_q  <= idx_q + 1'b1;
              // Thermometer fill keeps bit k from rising before bit k-1.
              rstn_q <= rstn_q | (rstn_q << 1);
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
        end
        default: begin
          state_q <= S_HOLD;
          cnt_q   <= '0;
          idx_q   <= '0;
          rstn_q  <= '0;
          done_q  <= 1'b0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign o_rstn_stage = rstn_q;
  assign o_rst_done   = done_q;
  assign o_busy       = busy_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Scoreboard bench for rst_seq_ctrl: default config plus a 1/1/1 corner
// instance share one stimulus stream and one run-length reference model.
module tb_rst_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1, stab = 1'b0, sw = 1'b0;
  logic [3:0] a_rstn;
  logic       a_done, a_busy;
  logic [0:0] b_rstn;
  logic       b_done, b_busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rst_seq_ctrl #(.NUM_STAGES(4), .HOLD_CYCLES(16), .GAP_CYCLES(8), .CNT_W(8)) u_a (
    .i_clk(clk), .i_rst(rst), .i_clk_stable(stab), .i_sw_rst_req(sw),
    .o_rstn_stage(a_rstn), .o_rst_done(a_done), .o_busy(a_busy));

  rst_seq_ctrl #(.NUM_STAGES(1), .HOLD_CYCLES(1), .GAP_CYCLES(1), .CNT_W(2)) u_b (
    .i_clk(clk), .i_rst(rst), .i_clk_stable(stab), .i_sw_rst_req(sw),
    .o_rstn_stage(b_rstn), .o_rst_done(b_done), .o_busy(b_busy));

  typedef struct packed {
    logic [3:0] a_rstn;
    logic       a_done;
    logic [0:0] b_rstn;
    logic       b_done;
  } exp_t;

  exp_t sb[$];

  // Reference: every non-qualifying edge (reset, clock loss, SW request)
  // zeroes the run length q; bit k is released once q >= HOLD + k*GAP,
  // done once q >= HOLD + NUM_STAGES*GAP.
  int q = 0;

  task automatic step(input logic r, input logic s, input logic w);
    exp_t e;
    @(negedge clk);
    rst = r; stab = s; sw = w;
    if (r || !s || w) q = 0;
    else if (q < 1000000) q++;
    for (int k = 0; k < 4; k++) e.a_rstn[k] = (q >= 16 + 8 * k);
    e.a_done    = (q >= 16 + 4 * 8);
    e.b_rstn[0] = (q >= 1);
    e.b_done    = (q >= 2);
    sb.push_back(e);
  endtask

  task automatic run(input int n, input logic r, input logic s, input logic w);
    for (int i = 0; i < n; i++) step(r, s, w);
  endtask

  function automatic void chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Monitor: one expected record per edge, compared 1 time unit after it.
  always @(posedge clk) begin
    exp_t e;
    logic [3:0] therm;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("a_rstn", int'(a_rstn), int'(e.a_rstn));
      chk("a_done", int'(a_done), int'(e.a_done));
      chk("a_busy", int'(a_busy), int'(!e.a_done));
      chk("b_rstn", int'(b_rstn), int'(e.b_rstn));
      chk("b_done", int'(b_done), int'(e.b_done));
      chk("b_busy", int'(b_busy), int'(!e.b_done));
      therm = a_rstn & (a_rstn + 4'd1);
      chk("a_order", int'(therm), 0);
    end
  end

  initial begin
    // Clean release with defaults, then stable afterwards.
    run(3, 1, 1, 0);
    run(60, 0, 1, 0);
    // Late clock-good.
    run(2, 1, 0, 0);
    run(30, 0, 0, 0);
    run(60, 0, 1, 0);
    // Clock loss right after bit 1 rises, then full repeat.
    run(1, 1, 1, 0);
    run(25, 0, 1, 0);
    run(1, 0, 0, 0);
    run(55, 0, 1, 0);
    // SW pulse from done, then a 5-cycle request during hold.
    run(1, 0, 1, 1);
    run(3, 0, 1, 0);
    run(5, 0, 1, 1);
    run(55, 0, 1, 0);
    // SW request on the edge where done would have asserted.
    run(1, 1, 1, 0);
    run(47, 0, 1, 0);
    run(1, 0, 1, 1);
    run(10, 0, 1, 0);
    // Reset together with SW request.
    run(2, 1, 1, 1);
    run(50, 0, 1, 0);
    // Randomized traffic with rare disturbances.
    for (int i = 0; i < 3000; i++) begin
      logic r, s, w;
      r = ($urandom_range(0, 299) == 0);
      s = ($urandom_range(0, 149) != 0);
      w = ($urandom_range(0, 149) == 0);
      step(r, s, w);
    end
    run(60, 0, 1, 0);
    repeat (3) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d records left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rst_seq_ctrl.md
# rst_seq_ctrl

Reset release sequencer that takes the already-synchronized reset of one clock domain and releases a set of per-stage active-low resets one after another. Typical stages, in release order, are memories, datapath, control, then the bus interface. The block sits directly downstream of the reset synchronizer; that synchronizer's output is inverted to drive `i_rst`. It enforces a minimum assertion time, waits for clock-good, re-asserts on clock loss or software request, and reports completion.

## Interface
- `NUM_STAGES`, 4: number of sequenced reset outputs; legal range 1..16.
- `HOLD_CYCLES`, 16: minimum cycles with all stages held in reset after `i_rst` drops; must be ≥1.
- `GAP_CYCLES`, 8: cycles between successive stage releases, and from the last release to done; must be ≥1.
- `CNT_W`, 8: counter width; must satisfy 2^CNT_W > max(HOLD_CYCLES, GAP_CYCLES).
- `i_clk` input 1: single clock. Everything is clocked on the rising edge.
- `i_rst` input 1: synchronous, active-high reset. Highest priority.
- `i_clk_stable` input 1: clock-good / PLL lock, already synchronous to `i_clk`.
- `i_sw_rst_req` input 1: software reset request, level-sampled each cycle.
- `o_rstn_stage` output NUM_STAGES: active-low stage resets, registered; bit 0 is released first.
- `o_rst_done` output 1: high once all stages are released and the final gap has elapsed; registered.
- `o_busy` output 1: high whenever the block is not in S_DONE; registered.

## Operation
- FSM states: S_HOLD, S_REL, S_DONE. State register, `cnt[CNT_W-1:0]`, stage index `idx`, and all outputs are flops.
- **`i_rst` = 1** (any state)
  - Next state S_HOLD; `cnt` = 0, `idx` = 0.
  - `o_rstn_stage` = all 0, `o_rst_done` = 0, `o_busy` = 1.
- **S_HOLD**
  - All stages asserted (all 0), done = 0.
  - If `i_clk_stable` = 0 or `i_sw_rst_req` = 1: `cnt` is cleared to 0, so the hold window restarts.
  - Otherwise `cnt` increments.
  - When `cnt` == HOLD_CYCLES-1 and the qualifying condition holds: go to S_REL, set `o_rstn_stage[0]` = 1, `cnt` = 0, `idx` = 0.
- **S_REL**
  - `cnt` increments each cycle.
  - When `cnt` == GAP_CYCLES-1:
    - If `idx` == NUM_STAGES-1: go to S_DONE, `o_rst_done` = 1, `o_busy` = 0.
    - Otherwise: `idx` += 1, set `o_rstn_stage[idx+1]` = 1, `cnt` = 0.
  - Already-released bits stay 1.
- **S_DONE**
  - Holds all ones, done = 1.
- **Abort** (in S_REL or S_DONE, when `i_clk_stable` = 0 or `i_sw_rst_req` = 1)
  - Next edge: go to S_HOLD; all `o_rstn_stage` = 0 simultaneously; done = 0; busy = 1; `cnt` = 0, `idx` = 0.
  - Abort has priority over a release or done transition due in the same cycle.
- **Ordering guarantee:** bit k is never 1 while bit k-1 is 0. On assertion, all bits drop in the same cycle.
- With NUM_STAGES = 1, only bit 0 is released, followed by the gap and then done.

## Timing
- Reset values: `o_rstn_stage` = {NUM_STAGES{1'b0}}, `o_rst_done` = 0, `o_busy` = 1.
- Numbering: edge 0 is the last edge at which `i_rst` is sampled 1. `i_rst` = 0, `i_clk_stable` = 1 and `i_sw_rst_req` = 0 are then sampled from edge 1 onward.
- `o_rstn_stage[k]` rises at edge HOLD_CYCLES + k·GAP_CYCLES.
- `o_rst_done` rises and `o_busy` falls at edge HOLD_CYCLES + NUM_STAGES·GAP_CYCLES.
- With defaults, bit 0 rises at 16, bit 1 at 24, bit 2 at 32, bit 3 at 40; done at 48.
- Abort latency: one edge from sampling the abort condition to all stages being 0.
- The full sequence restarts from the HOLD timing, counted from the first qualifying cycle.
- No combinational path from any input to any output.

## Test plan
- **Defaults, clean release:** deassert `i_rst` with `i_clk_stable` = 1 -> bits 0..3 rise at edges 16/24/32/40; done rises and busy falls at 48; outputs are stable afterwards.
- **Late clock-good:** hold `i_clk_stable` = 0 for 30 cycles after reset, then raise it -> bit 0 rises 16 edges after the first cycle sampled stable; no earlier release.
- **Clock loss mid-sequence:** drop `i_clk_stable` for 1 cycle right after bit 1 rises -> next edge all bits are 0 and busy = 1; after restoration the full 16/24/32/40/48 sequence repeats.
- **Software reset:** from S_DONE, pulse `i_sw_rst_req` for 1 cycle -> all bits 0 and done 0 next edge. Then hold the request high for 5 cycles during S_HOLD -> release of bit 0 is delayed by 16 cycles after the request drops.
- **Simultaneous events:** raise `i_sw_rst_req` on the exact cycle `cnt` == GAP_CYCLES-1 for the last stage -> done never asserts, block returns to S_HOLD. Assert `i_rst` together with `i_sw_rst_req` -> reset values are applied.
- **Parameter corner:** NUM_STAGES = 1, HOLD_CYCLES = 1, GAP_CYCLES = 1 -> bit 0 rises at edge 1, done at edge 2; throughout all runs, a checker asserts bit k ≤ bit k-1 every cycle.
